// File: rtl/regfile_multiport.sv
// regfile_multiport -- MIPS general-purpose register file for the decode stage.
//
// The block has these ports:
//   - NUM_READ combinational read ports. Each port k uses bits
//     [k*REGFILE_WIDTH +: REGFILE_WIDTH] of addressR and the matching
//     [k*DATA_WIDTH +: DATA_WIDTH] slice of regR.
//   - One write port (we/addressW/data) driven by writeback.
//   - A handshaked register dump stream for the debug path
//     (dumpStart/dumpReady in; dumpBusy/dumpValid/dumpAddr/dumpData/dumpDone out).
//
// Common controls:
//   - clk: every state update happens on its rising edge.
//   - reset: asynchronous, active-high. It clears the array and the dump FSM.
//   - clkEnable: gates every state update. It does not affect reads.
//
// Optional feature, macro REGFILE_BYPASS_EN:
//   - When defined, a write in the current cycle is forwarded to any read port
//     that has the same address.
//   - When undefined, reads always return the stored array value.
//
// Register 0 reads as zero when ZERO_REG=1. Writes to register 0 are then dropped.

// One read port (one lane): zero-register masking and write-through selection.
module regfile_rdport #(
  parameter int DATA_WIDTH    = 32,
  parameter int REGFILE_WIDTH = 5,
  parameter int ZERO_REG      = 1
) (
  input  logic [REGFILE_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    raw,    // array content at addr
  input  logic                     hit,    // same-cycle write to addr
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH-1:0]    rdata
);
  // Zero masking takes priority, so forwarding never reaches register 0.
  assign rdata = (ZERO_REG != 0 && addr == '0) ? '0 :
                 hit                           ? wdata : raw;
endmodule

module regfile_multiport #(
  parameter int DATA_WIDTH    = 32,
  parameter int REGFILE_WIDTH = 5,
  parameter int NUM_READ      = 2,
  parameter int ZERO_REG      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clkEnable,
  input  logic                              we,
  input  logic [REGFILE_WIDTH-1:0]          addressW,
  input  logic [DATA_WIDTH-1:0]             data,
  input  logic [NUM_READ*REGFILE_WIDTH-1:0] addressR,
  output logic [NUM_READ*DATA_WIDTH-1:0]    regR,
  input  logic                              dumpStart,
  input  logic                              dumpReady,
  output logic                              dumpBusy,
  output logic                              dumpValid,
  output logic [REGFILE_WIDTH-1:0]          dumpAddr,
  output logic [DATA_WIDTH-1:0]             dumpData,
  output logic                              dumpDone
);
  localparam int DEPTH = 1 << REGFILE_WIDTH;
  localparam logic [REGFILE_WIDTH-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  logic [DATA_WIDTH-1:0] banco [DEPTH];

  // ---------------- write port ----------------
  logic wr_ok;
  assign wr_ok = clkEnable & we & ~(ZERO_REG != 0 && addressW == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) banco[i] <= '0;
    end else if (wr_ok) begin
      banco[addressW] <= data;
    end
  end

  // ---------------- read ports ----------------
  logic [NUM_READ-1:0]                 rd_hit;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_raw;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rd_data;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [REGFILE_WIDTH-1:0] ra;
    assign ra        = addressR[k*REGFILE_WIDTH +: REGFILE_WIDTH];
    assign rd_raw[k] = banco[ra];
`ifdef REGFILE_BYPASS_EN
    assign rd_hit[k] = clkEnable & we & (addressW == ra);
`else
    assign rd_hit[k] = 1'b0;
`endif
    regfile_rdport #(
      .DATA_WIDTH(DATA_WIDTH), .REGFILE_WIDTH(REGFILE_WIDTH), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .addr(ra), .raw(rd_raw[k]), .hit(rd_hit[k]), .wdata(data), .rdata(rd_data[k])
    );
    assign regR[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[k];
  end

  // ---------------- dump FSM ----------------
  state_t                   state, state_nxt;
  logic [REGFILE_WIDTH-1:0] idx, idx_nxt, idx_inc;
  logic [DATA_WIDTH-1:0]    snap, snap_nxt;

  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      snap  <= snap_nxt;
    end
  end

  // The snapshot reads banco combinationally here. It therefore captures the
  // contents before any write that commits on the same edge. It only changes
  // when a new entry is selected, so it holds under backpressure even if that
  // register is rewritten.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    snap_nxt  = snap;
    if (clkEnable) begin
      case (state)
        S_IDLE: if (dumpStart) begin
          state_nxt = S_SEND;
          idx_nxt   = '0;
          snap_nxt  = banco[0];
        end
        S_SEND: if (dumpReady) begin
          if (idx == LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt  = idx_inc;
            snap_nxt = banco[idx_inc];
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          idx_nxt   = '0;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign dumpBusy  = (state == S_SEND);
  assign dumpValid = (state == S_SEND);
  assign dumpDone  = (state == S_DONE);
  assign dumpAddr  = idx;
  assign dumpData  = snap;
endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;
  logic        clk = 0;
  logic        reset;
  logic        clkEnable;
  logic        we;
  logic [4:0]  addressW;
  logic [31:0] data;
  logic [9:0]  addressR;
  logic [63:0] regR;
  logic        dumpStart, dumpReady;
  logic        dumpBusy, dumpValid, dumpDone;
  logic [4:0]  dumpAddr;
  logic [31:0] dumpData;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_reg [32];

  regfile_multiport dut (
    .clk(clk), .reset(reset), .clkEnable(clkEnable), .we(we),
    .addressW(addressW), .data(data), .addressR(addressR), .regR(regR),
    .dumpStart(dumpStart), .dumpReady(dumpReady), .dumpBusy(dumpBusy),
    .dumpValid(dumpValid), .dumpAddr(dumpAddr), .dumpData(dumpData),
    .dumpDone(dumpDone)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks happen 1 unit later.
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; addressW = a; data = d;
    step();
    we = 0;
    if (a != 0) exp_reg[a] = d;
  endtask

  task automatic test_reset();
    reset = 1; clkEnable = 1; we = 0; addressW = 0; data = 0;
    addressR = 0; dumpStart = 0; dumpReady = 0;
    for (int i = 0; i < 32; i++) exp_reg[i] = 0;
    step(); step();
    #1;
    total++; if (dumpValid !== 1'b0 || dumpBusy !== 1'b0 || dumpDone !== 1'b0) begin
      bad++; $display("FAIL reset_flags got v=%b b=%b d=%b want 0", dumpValid, dumpBusy, dumpDone); end
    total++; if (dumpAddr !== 5'd0 || dumpData !== 32'd0) begin
      bad++; $display("FAIL reset_dumpbus got addr=%0d data=%h want 0", dumpAddr, dumpData); end
    reset = 0;
    step();
    addressR = {5'd1, 5'd0}; #1;
    total++; if (regR !== 64'd0) begin
      bad++; $display("FAIL reset_read_0_1 got %h want 0", regR); end
    addressR = {5'd31, 5'd31}; #1;
    total++; if (regR !== 64'd0) begin
      bad++; $display("FAIL reset_read_31 got %h want 0", regR); end
  endtask

  task automatic test_write_read();
    wr(5'd7, 32'hDEADBEEF);
    addressR = {5'd7, 5'd7}; #1;
    total++; if (regR !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      bad++; $display("FAIL rd_r7_both got %h want deadbeefdeadbeef", regR); end
    wr(5'd31, 32'h0BADF00D);
    addressR = {5'd7, 5'd31}; #1;
    total++; if (regR !== {32'hDEADBEEF, 32'h0BADF00D}) begin
      bad++; $display("FAIL rd_r31_r7 got %h want deadbeef0badf00d", regR); end
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'h1234);
    addressR = {5'd7, 5'd0}; #1;
    total++; if (regR[31:0] !== 32'd0) begin
      bad++; $display("FAIL zero_reg got %h want 0", regR[31:0]); end
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'h11111111);
    addressR = {5'd7, 5'd9};
    we = 1; addressW = 5'd9; data = 32'hA5A5A5A5; #1;
`ifdef REGFILE_BYPASS_EN
    total++; if (regR[31:0] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_same_cycle got %h want a5a5a5a5", regR[31:0]); end
`else
    total++; if (regR[31:0] !== 32'h11111111) begin
      bad++; $display("FAIL nobypass_same_cycle got %h want 11111111", regR[31:0]); end
`endif
    step(); we = 0; exp_reg[9] = 32'hA5A5A5A5; #1;
    total++; if (regR[31:0] !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL bypass_next_cycle got %h want a5a5a5a5", regR[31:0]); end
  endtask

  task automatic finish_dump(input string nm);
    int n = 0;
    dumpReady = 1;
    #1;
    while (dumpDone !== 1'b1 && n < 100) begin step(); #1; n++; end
    total++; if (dumpDone !== 1'b1) begin
      bad++; $display("FAIL %s_done_timeout got done=%b want 1", nm, dumpDone); end
    step();
  endtask

  task automatic test_dump();
    for (int i = 0; i < 32; i++) wr(i[4:0], i * 3);
    dumpReady = 1; dumpStart = 1;
    step(); dumpStart = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++; if (dumpValid !== 1'b1 || dumpBusy !== 1'b1 || dumpAddr !== i[4:0] ||
                   dumpData !== 32'(i * 3) || dumpDone !== 1'b0) begin
        bad++; $display("FAIL dump_beat%0d got v=%b addr=%0d data=%0d done=%b want v=1 addr=%0d data=%0d done=0",
                        i, dumpValid, dumpAddr, dumpData, dumpDone, i, i * 3); end
      step();
    end
    #1;
    total++; if (dumpDone !== 1'b1 || dumpValid !== 1'b0) begin
      bad++; $display("FAIL dump_done_pulse got done=%b v=%b want done=1 v=0", dumpDone, dumpValid); end
    step(); #1;
    total++; if (dumpDone !== 1'b0 || dumpValid !== 1'b0 || dumpAddr !== 5'd0) begin
      bad++; $display("FAIL dump_idle_after got done=%b v=%b addr=%0d want 0 0 0", dumpDone, dumpValid, dumpAddr); end
  endtask

  task automatic test_backpressure();
    dumpReady = 1; dumpStart = 1;
    step(); dumpStart = 0;
    for (int i = 0; i < 10; i++) step();
    dumpReady = 0; dumpStart = 1;
    we = 1; addressW = 5'd10; data = 32'hFFFF;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (dumpValid !== 1'b1 || dumpAddr !== 5'd10 || dumpData !== 32'd30) begin
        bad++; $display("FAIL bp_hold_c%0d got v=%b addr=%0d data=%0d want v=1 addr=10 data=30",
                        c, dumpValid, dumpAddr, dumpData); end
      step(); we = 0;
    end
    exp_reg[10] = 32'hFFFF;
    dumpStart = 0; dumpReady = 1; #1;
    total++; if (dumpAddr !== 5'd10 || dumpData !== 32'd30) begin
      bad++; $display("FAIL bp_release got addr=%0d data=%0d want 10 30", dumpAddr, dumpData); end
    step(); #1;
    total++; if (dumpAddr !== 5'd11 || dumpData !== 32'd33) begin
      bad++; $display("FAIL bp_next_beat got addr=%0d data=%0d want 11 33", dumpAddr, dumpData); end
    finish_dump("bp");
    #1;
    total++; if (dumpValid !== 1'b0 || dumpBusy !== 1'b0) begin
      bad++; $display("FAIL bp_start_not_queued got v=%b b=%b want 0 0", dumpValid, dumpBusy); end
  endtask

  task automatic test_clken();
    dumpReady = 1; dumpStart = 1;
    step(); dumpStart = 0;
    for (int i = 0; i < 5; i++) step();
    clkEnable = 0; we = 1; addressW = 5'd3; data = 32'hBEEF;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (dumpAddr !== 5'd5 || dumpData !== 32'd15 || dumpValid !== 1'b1) begin
        bad++; $display("FAIL ce_freeze_c%0d got addr=%0d data=%0d v=%b want 5 15 1",
                        c, dumpAddr, dumpData, dumpValid); end
      step();
    end
    clkEnable = 1; we = 0;
    addressR = {5'd3, 5'd3}; #1;
    total++; if (regR !== {exp_reg[3], exp_reg[3]}) begin
      bad++; $display("FAIL ce_no_write got %h want %h%h", regR, exp_reg[3], exp_reg[3]); end
    total++; if (dumpAddr !== 5'd5) begin
      bad++; $display("FAIL ce_resume_same got addr=%0d want 5", dumpAddr); end
    step(); #1;
    total++; if (dumpAddr !== 5'd6 || dumpData !== 32'd18) begin
      bad++; $display("FAIL ce_resume_next got addr=%0d data=%0d want 6 18", dumpAddr, dumpData); end
    finish_dump("ce");
  endtask

  task automatic test_reset_middump();
    dumpReady = 1; dumpStart = 1;
    step(); dumpStart = 0;
    for (int i = 0; i < 5; i++) step();
    #1;
    total++; if (dumpAddr !== 5'd5) begin
      bad++; $display("FAIL rst_mid_pre got addr=%0d want 5", dumpAddr); end
    reset = 1; #1;
    addressR = {5'd31, 5'd7}; #1;
    total++; if (dumpValid !== 1'b0 || dumpBusy !== 1'b0 || dumpAddr !== 5'd0 || dumpData !== 32'd0) begin
      bad++; $display("FAIL rst_mid_dump got v=%b b=%b addr=%0d data=%0d want all 0",
                      dumpValid, dumpBusy, dumpAddr, dumpData); end
    total++; if (regR !== 64'd0) begin
      bad++; $display("FAIL rst_mid_regs got %h want 0", regR); end
    step(); reset = 0; step(); #1;
    total++; if (dumpValid !== 1'b0 || dumpDone !== 1'b0) begin
      bad++; $display("FAIL rst_mid_idle got v=%b done=%b want 0 0", dumpValid, dumpDone); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_dump();
    test_backpressure();
    test_clken();
    test_reset_middump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
